// File: rtl/soc_system_pll_seq_pkg.sv
// Shared types and constants for the fabric PLL reset sequencer.
package soc_system_pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_seq_state_t;

    localparam int LOL_COUNT_W = 8;

    // Largest of three cycle counts; sizes the shared cycle counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/soc_system_sync2.sv
// Two-flop synchronizer for a single asynchronous status bit.
module soc_system_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/soc_system_pll_reset_sequencer.sv
// Fabric PLL reset / lock-qualification sequencer, clocked by refclk only.
// Optional build macro PLL_SEQ_AUTO_RELOCK_EN: when defined, lock loss in RUN
// restarts the sequence automatically; otherwise it parks in FAULT until
// software issues relock_req.
module soc_system_pll_reset_sequencer
    import soc_system_pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                                   refclk,
    input  logic                                   rst,
    input  logic                                   locked,
    input  logic                                   relock_req,
    output logic                                   pll_rst,
    output logic                                   sys_rst,
    output logic                                   ready,
    output logic                                   fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]       retry_cnt,
    output logic [LOL_COUNT_W-1:0]                 lol_count
);

    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam int CNT_W   = $clog2(max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                         LOCK_STABLE_CYCLES)) + 1;

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_DONE  = CNT_W'(LOCK_STABLE_CYCLES);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    pll_seq_state_t         state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    logic [LOL_COUNT_W-1:0] lol_q, lol_d;
    logic                   pll_rst_q, sys_rst_q, ready_q, fault_q;
    logic                   lock_s;

    soc_system_sync2 u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (locked),
        .q_o   (lock_s)
    );

    // Next-state, shared cycle counter, retry and loss-of-lock bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        lol_d   = lol_q;

        case (state_q)
            RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (retry_q == RETRY_LIMIT) begin
                        state_d = FAULT;
                    end else begin
                        state_d = RESET_PLL;
                        retry_d = retry_q + RETRY_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE: begin
                // A glitch restarts qualification but is not a failed attempt.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_DONE) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    if (lol_q != '1) begin
                        lol_d = lol_q + LOL_COUNT_W'(1);
                    end
                    cnt_d = '0;
`ifdef PLL_SEQ_AUTO_RELOCK_EN
                    state_d = RESET_PLL;
                    retry_d = '0;
`else
                    state_d = FAULT;
`endif
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = RESET_PLL;
                cnt_d   = '0;
            end
        endcase

        // Software relock overrides any transition but keeps the lol update above.
        if (relock_req) begin
            state_d = RESET_PLL;
            cnt_d   = '0;
            retry_d = '0;
        end
    end

    // State, counters and outputs; outputs decode the next state so they
    // change on the same edge as the state register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            lol_q     <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            lol_q     <= lol_d;
            pll_rst_q <= (state_d == RESET_PLL) || (state_d == FAULT);
            sys_rst_q <= (state_d != RUN);
            ready_q   <= (state_d == RUN);
            fault_q   <= (state_d == FAULT);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;
    assign lol_count = lol_q;

endmodule
